// File: rtl/tiq_sd_dac.sv
// tiq_sd_dac: first-order sigma-delta DAC modulator.
// Accepts unsigned samples over a valid/ready handshake into a one-entry
// buffer. Once per OSR enabled clocks the buffered sample moves into the
// active register. The accumulator carry forms the 1-bit pulse-density output.
module tiq_sd_dac #(
    parameter int WIDTH = 8,
    parameter int OSR   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dac_out,
    output logic             sample_strobe,
    output logic             underrun
);

    // OSR is a power of two >= 2, so PW bits cover 0..OSR-1 exactly.
    localparam int            PW         = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);

    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_acc;
    logic             r_dac;
    logic [PW-1:0]    r_phase;

    logic             w_accept;
    logic             w_load;
    logic [WIDTH:0]   w_sum;

    // Handshake: a sample transfers on a rising edge where in_valid and
    // in_ready are both high. in_ready is simply "buffer empty". It does not
    // depend on in_valid or enable, so samples can be queued while the
    // modulator is stopped. in_data is ignored while in_ready is low.
    assign in_ready = !r_pend_valid;
    assign w_accept = in_valid && !r_pend_valid;

    // The load cycle is the last phase of an enabled sample period.
    assign w_load        = enable && (r_phase == PHASE_LAST);
    assign sample_strobe = w_load;
    assign underrun      = w_load && !r_pend_valid;

    // The carry out of the accumulator add is the next output bit.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_cur};
    assign dac_out = r_dac;

    // One-entry input buffer: fill on handshake, drain on load.
    // Both cannot happen together because in_ready is low while it is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_accept) begin
            r_pend       <= in_data;
            r_pend_valid <= 1'b1;
        end else if (w_load && r_pend_valid) begin
            r_pend_valid <= 1'b0;
        end
    end

    // Active sample: replaced only on a load with a buffered sample. Otherwise
    // it holds, so an underrun repeats the previous level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur <= '0;
        end else if (w_load && r_pend_valid) begin
            r_cur <= r_pend;
        end
    end

    // Phase counter: free-runs while enabled and parks at zero when disabled.
    // As a result, the first load after re-enable falls on the OSR-th enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (!enable) begin
            r_phase <= '0;
        end else if (r_phase == PHASE_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Modulator: accumulate the active sample and register the carry.
    // When disabled, clear it so the pin idles low and restarts cleanly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else if (!enable) begin
            r_acc <= '0;
            r_dac <= 1'b0;
        end else begin
            r_acc <= w_sum[WIDTH-1:0];
            r_dac <= w_sum[WIDTH];
        end
    end

endmodule

// File: tb/tb_tiq_sd_dac.sv
// Testbench for tiq_sd_dac: a cycle-level reference model predicts in_ready,
// sample_strobe and underrun each cycle. It also predicts the dac_out bit
// for each edge, which is queued and compared after the edge.
// Scenario tasks add their own density, timing and ordering checks.
module tb_tiq_sd_dac;

    localparam int WIDTH = 8;
    localparam int OSR   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dac_out;
    logic             sample_strobe;
    logic             underrun;

    tiq_sd_dac #(.WIDTH(WIDTH), .OSR(OSR)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dac_out       (dac_out),
        .sample_strobe (sample_strobe),
        .underrun      (underrun)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Bookkeeping
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Scoreboard: expected dac_out after each edge
    logic [0:0] exp_q[$];

    // Reference model state
    logic [WIDTH-1:0] m_pend;
    logic             m_pv;
    logic [WIDTH-1:0] m_cur;
    int               m_phase;
    int               m_acc;

    // Per-cycle DUT observations used by the scenario tasks
    logic        obs_hs;
    logic        obs_strobe;
    logic        obs_underrun;
    int          ones_cnt;
    logic [15:0] pat;

    task automatic model_reset();
        m_pend  = '0;
        m_pv    = 1'b0;
        m_cur   = '0;
        m_phase = 0;
        m_acc   = 0;
        exp_q.delete();
    endtask

    // One clock: check combinational outputs mid-cycle, step the model,
    // push the predicted output bit, then pop and compare after the edge.
    task automatic cycle();
        logic       hs;
        logic       ld;
        logic [0:0] exp_dac;
        logic [0:0] got_exp;
        int         sum;
        @(negedge clk);
        hs = in_valid && !m_pv;
        ld = enable && (m_phase == OSR - 1);
        n_checks++; if (in_ready !== !m_pv) $display("FAIL sb_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !m_pv); else n_pass++;
        n_checks++; if (sample_strobe !== ld) $display("FAIL sb_strobe cyc=%0d got=%b exp=%b", cyc, sample_strobe, ld); else n_pass++;
        n_checks++; if (underrun !== (ld && !m_pv)) $display("FAIL sb_underrun cyc=%0d got=%b exp=%b", cyc, underrun, ld && !m_pv); else n_pass++;
        obs_hs       = in_valid && in_ready;
        obs_strobe   = sample_strobe;
        obs_underrun = underrun;
        if (enable) begin
            sum     = m_acc + int'(m_cur);
            exp_dac = (sum >= (1 << WIDTH)) ? 1'b1 : 1'b0;
            m_acc   = sum & ((1 << WIDTH) - 1);
            m_phase = (m_phase + 1) % OSR;
        end else begin
            exp_dac = 1'b0;
            m_acc   = 0;
            m_phase = 0;
        end
        if (ld && m_pv) begin
            m_cur = m_pend;
            m_pv  = 1'b0;
        end
        if (hs) begin
            m_pend = in_data;
            m_pv   = 1'b1;
        end
        exp_q.push_back(exp_dac);
        @(posedge clk);
        #1;
        got_exp = exp_q.pop_front();
        n_checks++; if (dac_out !== got_exp) $display("FAIL sb_dac_out cyc=%0d got=%b exp=%b", cyc, dac_out, got_exp); else n_pass++;
        ones_cnt += (dac_out === 1'b1) ? 1 : 0;
        pat = {pat[14:0], dac_out};
        cyc++;
    endtask

    // Run cycles until the DUT strobes; cnt is the number of cycles run.
    task automatic wait_strobe(input int budget, output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!obs_strobe && cnt < budget);
        n_checks++; if (obs_strobe !== 1'b1) $display("FAIL wait_strobe_timeout cyc=%0d got=no_strobe exp=strobe within %0d", cyc, budget); else n_pass++;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        n_checks++; if (dac_out !== 1'b0) $display("FAIL reset_dac_out got=%b exp=0", dac_out); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (sample_strobe !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", sample_strobe); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b exp=0", underrun); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ones_cnt = 0;
        pat      = '0;
        repeat (3) cycle();
    endtask

    task automatic test_midscale();
        int cnt;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h80;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL mid_accept got=%b exp=1", obs_hs); else n_pass++;
        in_valid = 1'b0;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (cnt != OSR - 1) $display("FAIL mid_first_load_cycle got=%0d exp=%0d", cnt, OSR - 1); else n_pass++;
        n_checks++; if (obs_underrun !== 1'b0) $display("FAIL mid_load_underrun got=%b exp=0", obs_underrun); else n_pass++;
        ones_cnt = 0;
        pat      = '0;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (cnt != OSR) $display("FAIL mid_strobe_period got=%0d exp=%0d", cnt, OSR); else n_pass++;
        n_checks++; if (ones_cnt != 8) $display("FAIL mid_ones got=%0d exp=8", ones_cnt); else n_pass++;
        n_checks++; if (pat !== 16'h5555) $display("FAIL mid_pattern got=%h exp=5555", pat); else n_pass++;
        n_checks++; if (obs_underrun !== 1'b1) $display("FAIL mid_idle_underrun got=%b exp=1", obs_underrun); else n_pass++;
    endtask

    task automatic test_extremes();
        int cnt;
        in_valid = 1'b1;
        in_data  = 8'h00;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL ext_zero_accept got=%b exp=1", obs_hs); else n_pass++;
        in_valid = 1'b0;
        wait_strobe(2 * OSR, cnt);
        ones_cnt = 0;
        repeat (2 * OSR) cycle();
        n_checks++; if (ones_cnt != 0) $display("FAIL ext_zero_ones got=%0d exp=0", ones_cnt); else n_pass++;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL ext_full_accept got=%b exp=1", obs_hs); else n_pass++;
        in_valid = 1'b0;
        wait_strobe(2 * OSR, cnt);
        ones_cnt = 0;
        repeat (256) cycle();
        n_checks++; if (ones_cnt != 255) $display("FAIL ext_full_ones got=%0d exp=255", ones_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cnt;
        in_valid = 1'b1;
        in_data  = 8'h10;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL bp_first_accept got=%b exp=1", obs_hs); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_low got=%b exp=0", in_ready); else n_pass++;
        in_data = 8'h20;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (obs_underrun !== 1'b0) $display("FAIL bp_load1_underrun got=%b exp=0", obs_underrun); else n_pass++;
        ones_cnt = 0;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL bp_accept_0x20 got=%b exp=1", obs_hs); else n_pass++;
        in_data = 8'h30;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (ones_cnt != 1) $display("FAIL bp_ones_0x10 got=%0d exp=1", ones_cnt); else n_pass++;
        n_checks++; if (cnt != OSR - 1) $display("FAIL bp_period got=%0d exp=%0d", cnt, OSR - 1); else n_pass++;
        ones_cnt = 0;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL bp_accept_0x30 got=%b exp=1", obs_hs); else n_pass++;
        in_valid = 1'b0;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (ones_cnt != 2) $display("FAIL bp_ones_0x20 got=%0d exp=2", ones_cnt); else n_pass++;
        ones_cnt = 0;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (ones_cnt != 3) $display("FAIL bp_ones_0x30 got=%0d exp=3", ones_cnt); else n_pass++;
        n_checks++; if (obs_underrun !== 1'b1) $display("FAIL bp_drained_underrun got=%b exp=1", obs_underrun); else n_pass++;
    endtask

    task automatic test_underrun();
        int cnt;
        for (int k = 0; k < 3; k++) begin
            ones_cnt = 0;
            wait_strobe(2 * OSR, cnt);
            n_checks++; if (obs_underrun !== 1'b1) $display("FAIL ur_pulse k=%0d got=%b exp=1", k, obs_underrun); else n_pass++;
            n_checks++; if (ones_cnt != 3) $display("FAIL ur_density k=%0d got=%0d exp=3", k, ones_cnt); else n_pass++;
            n_checks++; if (cnt != OSR) $display("FAIL ur_period k=%0d got=%0d exp=%0d", k, cnt, OSR); else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        int cnt;
        repeat (5) cycle();
        in_valid = 1'b1;
        in_data  = 8'h55;
        cycle();
        n_checks++; if (obs_hs !== 1'b1) $display("FAIL en_queue_accept got=%b exp=1", obs_hs); else n_pass++;
        in_valid = 1'b0;
        enable   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_checks++; if (dac_out !== 1'b0) $display("FAIL en_off_dac k=%0d got=%b exp=0", k, dac_out); else n_pass++;
            n_checks++; if (obs_strobe !== 1'b0) $display("FAIL en_off_strobe k=%0d got=%b exp=0", k, obs_strobe); else n_pass++;
        end
        enable = 1'b1;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (cnt != OSR) $display("FAIL en_first_strobe got=%0d exp=%0d", cnt, OSR); else n_pass++;
        n_checks++; if (obs_underrun !== 1'b0) $display("FAIL en_pend_loaded got=%b exp=0", obs_underrun); else n_pass++;
        wait_strobe(2 * OSR, cnt);
        n_checks++; if (obs_underrun !== 1'b1) $display("FAIL en_pend_consumed got=%b exp=1", obs_underrun); else n_pass++;
    endtask

    task automatic test_async_reset();
        int strobe_at;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        cycle();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL ar_pend_full got=%b exp=0", in_ready); else n_pass++;
        rst = 1'b1;
        #2;
        n_checks++; if (dac_out !== 1'b0) $display("FAIL ar_dac_out got=%b exp=0", dac_out); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL ar_in_ready got=%b exp=1", in_ready); else n_pass++;
        n_checks++; if (sample_strobe !== 1'b0) $display("FAIL ar_strobe got=%b exp=0", sample_strobe); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL ar_underrun got=%b exp=0", underrun); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        ones_cnt  = 0;
        strobe_at = 0;
        for (int i = 1; i <= OSR; i++) begin
            cycle();
            if (obs_strobe === 1'b1 && strobe_at == 0) strobe_at = i;
        end
        n_checks++; if (strobe_at != OSR) $display("FAIL ar_first_strobe got=%0d exp=%0d", strobe_at, OSR); else n_pass++;
        n_checks++; if (obs_underrun !== 1'b1) $display("FAIL ar_pend_cleared got=%b exp=1", obs_underrun); else n_pass++;
        n_checks++; if (ones_cnt != 0) $display("FAIL ar_cur_cleared got=%0d exp=0", ones_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_midscale();
        test_extremes();
        test_back_to_back();
        test_underrun();
        test_enable_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
